hs_sync_fifo: RTL and testbench
===============================

HS_SYNC_FIFO -- requirements
Module: hs_sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, storage capacity in words (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, level at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, level at or below which almost_empty asserts.
REQ-005 The block SHALL have one clock, with reset asynchronous and active-low.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-009 The block SHALL have port s_valid, input, 1 bit: the writer offers s_data.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the FIFO accepts a word this cycle.
REQ-011 The block SHALL have port s_data, input, WIDTH bits: write data.
REQ-012 The block SHALL have port m_valid, output, 1 bit: m_data holds the head word.
REQ-013 The block SHALL have port m_ready, input, 1 bit: the reader consumes the head word.
REQ-014 The block SHALL have port m_data, output, WIDTH bits: head-of-queue data.
REQ-015 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-016 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: status flags.
REQ-017 The block SHALL have port overflow_err, output, 1 bit: sticky flag, set by s_valid while full.

Function
REQ-018 The FIFO SHALL store exactly DEPTH words, with no reserved slot.
REQ-019 A push SHALL occur on a rising clk when s_valid && s_ready.
REQ-020 A pop SHALL occur on a rising clk when m_valid && m_ready.
REQ-021 s_ready SHALL equal !full and SHALL NOT depend combinationally on m_ready.
REQ-022 m_valid SHALL equal !empty.
REQ-023 m_data SHALL show the oldest stored word (first-word fall-through), valid whenever m_valid=1.
REQ-024 A word pushed at edge N SHALL appear on m_data/m_valid after edge N, one cycle latency.
REQ-025 Pointers SHALL be clog2(DEPTH) bits and SHALL wrap naturally modulo DEPTH.
REQ-026 level SHALL change as follows: push only +1; pop only -1; push and pop together, unchanged.
REQ-027 full SHALL equal (level==DEPTH); empty SHALL equal (level==0).
REQ-028 almost_full SHALL equal (level>=AF_LEVEL); almost_empty SHALL equal (level<=AE_LEVEL).
REQ-029 When full, s_ready SHALL be 0 and no push SHALL occur, even if a pop happens the same cycle.
REQ-030 When empty, no pop SHALL occur regardless of m_ready, and m_data SHALL be don't-care.
REQ-031 When s_valid=1 and full=1, overflow_err SHALL be set on the next edge and held until reset or flush.
REQ-032 flush SHALL take priority over push and pop: next edge level=0, pointers=0, overflow_err=0.
REQ-033 Storage contents need not clear on flush.
REQ-034 All status outputs SHALL be decoded from registered state, with no input-to-output combinational path except through storage read.

Reset
REQ-035 While rstn=0, the block SHALL hold rd/wr pointers=0, level=0, overflow_err=0.
REQ-036 While rstn=0, the outputs SHALL be empty=1, full=0, m_valid=0, s_ready=1, almost_empty=1, almost_full=0.
REQ-037 Storage array SHALL NOT be reset.
REQ-038 Reset asserted mid-transfer SHALL discard all contents; no push or pop SHALL be recorded on the reset edge.

Structure
REQ-039 Shared package hs_fifo_pkg SHALL hold clog2 helper and default WIDTH/DEPTH constants.
REQ-040 Storage SHALL be one sub-module hs_fifo_mem (DEPTH x WIDTH, one write port, one asynchronous read port).
REQ-041 Pointer, level and flag control SHALL reside in hs_sync_fifo.

Verification
REQ-042 The bench SHALL cover reset fill: after reset, push 16 words 0x01..0x10 (DEPTH=16) -> level=16, full=1, s_ready=0, almost_full asserted at level 14.
REQ-043 The bench SHALL cover drain: from full, m_ready=1 for 16 cycles -> m_data 0x01..0x10 in order, then empty=1, m_valid=0.
REQ-044 The bench SHALL cover simultaneous push and pop: at level 5, s_valid=m_ready=1 for 40 cycles -> level stays 5, data order intact across pointer wrap.
REQ-045 The bench SHALL cover full with pop: at level=16, s_valid=1 and m_ready=1 -> pop occurs, no push, level=15, overflow_err=1.
REQ-046 The bench SHALL cover flush: at level 9 with overflow_err=1, pulse flush with s_valid=1 -> next cycle level=0, empty=1, overflow_err=0, no word written.
REQ-047 The bench SHALL cover async reset: drop rstn mid-burst between edges -> outputs take reset values immediately; after release, first pushed word 0xA5 is the first read.

Source files
------------

// File: rtl/hs_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the hs_sync_fifo family.
`timescale 1ns/1ps
package hs_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Ceiling log2 usable in parameter expressions; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
`timescale 1ns/1ps
module hs_fifo_mem
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers, so
  // clearing it would only cost a reset net on every storage bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hs_sync_fifo.sv
// Single-clock first-word fall-through FIFO with level, watermark flags and sticky overflow.
`timescale 1ns/1ps
module hs_sync_fifo
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow_err
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, wr_en;

  // Every status output is a pure decode of registered occupancy.
  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign s_ready      = !full;
  assign m_valid      = !empty;
  assign level        = level_q;
  assign overflow_err = overflow_q;

  // NOTE: each signal gets its hold value first so no path leaves it
  // unassigned, which keeps this block purely combinational (no latches).
  always_comb begin
    push       = s_valid && s_ready;
    pop        = m_valid && m_ready;
    wr_en      = push && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (s_valid && full) overflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  hs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_addr (rd_ptr_q),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Directed self-checking bench for hs_sync_fifo at WIDTH=8, DEPTH=16.
`timescale 1ns/1ps
module tb_hs_sync_fifo;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow_err;

  int n_cmp;
  int n_err;

  hs_sync_fifo #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({level, empty, full, m_valid, s_ready, almost_empty, almost_full, overflow_err} !==
        {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: level=%0d empty=%b full=%b m_valid=%b s_ready=%b ae=%b af=%b ovf=%b, want 0 1 0 0 1 1 0 0",
               tag, level, empty, full, m_valid, s_ready, almost_empty, almost_full, overflow_err);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_reset_outputs("after_release");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
      n_cmp++;
      if (level !== 5'(i) || almost_full !== (i >= 14) || almost_empty !== (i <= 2)) begin
        n_err++;
        $display("FAIL fill_level_%0d: level=%0d af=%b ae=%b, want %0d %b %b",
                 i, level, almost_full, almost_empty, i, (i >= 14), (i <= 2));
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || s_ready !== 1'b0 || m_data !== 8'h01 || m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_full: full=%b s_ready=%b m_data=%h m_valid=%b, want 1 0 01 1",
               full, s_ready, m_data, m_valid);
    end
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_word_%0d: m_valid=%b m_data=%h, want 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    n_cmp++;
    if (empty !== 1'b1 || m_valid !== 1'b0 || level !== 5'd0) begin
      n_err++;
      $display("FAIL drain_empty: empty=%b m_valid=%b level=%0d, want 1 0 0", empty, m_valid, level);
    end
    tick();
    m_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL pop_when_empty: level=%0d empty=%b, want 0 1", level, empty);
    end
  endtask

  // Head sequence: 0x20..0x24 preloaded, then 0x40+k pushed on cycle k.
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h20 + 8'(i);
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] exp_head;
      exp_head = (i < 5) ? 8'h20 + 8'(i) : 8'h40 + 8'(i - 5);
      s_data   = 8'h40 + 8'(i);
      n_cmp++;
      if (m_data !== exp_head) begin
        n_err++;
        $display("FAIL b2b_head_%0d: m_data=%h want %h", i, m_data, exp_head);
      end
      tick();
      n_cmp++;
      if (level !== 5'd5) begin
        n_err++;
        $display("FAIL b2b_level_%0d: level=%0d want 5", i, level);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  // Contents 0x63..0x67; top up with 0x80..0x8A to reach 16.
  task automatic test_full_with_pop();
    for (int i = 0; i < 11; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h80 + 8'(i);
      tick();
    end
    n_cmp++;
    if (level !== 5'd16 || full !== 1'b1 || overflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL topup_full: level=%0d full=%b ovf=%b, want 16 1 0", level, full, overflow_err);
    end
    s_data  = 8'hEE;
    m_ready = 1'b1;
    n_cmp++;
    if (m_data !== 8'h63 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fullpop_head: m_data=%h s_ready=%b, want 63 0", m_data, s_ready);
    end
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd15 || overflow_err !== 1'b1 || full !== 1'b0 || m_data !== 8'h64) begin
      n_err++;
      $display("FAIL fullpop_result: level=%0d ovf=%b full=%b m_data=%h, want 15 1 0 64",
               level, overflow_err, full, m_data);
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_heads [6];
    exp_heads = '{8'h64, 8'h65, 8'h66, 8'h67, 8'h80, 8'h81};
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (m_data !== exp_heads[i]) begin
        n_err++;
        $display("FAIL preflush_head_%0d: m_data=%h want %h", i, m_data, exp_heads[i]);
      end
      tick();
    end
    m_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd9 || overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL preflush_state: level=%0d ovf=%b, want 9 1", level, overflow_err);
    end
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (level !== 5'd0 || empty !== 1'b1 || overflow_err !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state: level=%0d empty=%b ovf=%b m_valid=%b, want 0 1 0 0",
               level, empty, overflow_err, m_valid);
    end
    s_valid = 1'b1;
    s_data  = 8'h33;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (level !== 5'd1 || m_data !== 8'h33) begin
      n_err++;
      $display("FAIL postflush_push: level=%0d m_data=%h, want 1 33", level, m_data);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hB0 + 8'(i);
      tick();
    end
    #3;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset_immediate");
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    check_reset_outputs("async_reset_held");
    @(negedge clk);
    rstn = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    tick();
    s_data  = 8'h5A;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (level !== 5'd2 || m_data !== 8'hA5) begin
      n_err++;
      $display("FAIL after_reset_first: level=%0d m_data=%h, want 2 a5", level, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd1 || m_data !== 8'h5A) begin
      n_err++;
      $display("FAIL after_reset_second: level=%0d m_data=%h, want 1 5a", level, m_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_with_pop();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
